// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI bridge read path.
package cpu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [7:0] LEN_SINGLE  = 8'd0;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

endpackage

// File: rtl/rd_grant_sel.sv
// Purpose: data-over-inst priority select with a saturating fetch starvation counter.
// Latency: grants are combinational in the arbitration cycle; counter updates on the next edge.
// Backpressure: no grant is issued while arb_en is low.
module rd_grant_sel #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved    = (starve_cnt == LIMIT);
  assign grant_inst = arb_en && inst_req && (!data_req || starved);
  // data still wins when the counter is full but fetch has gone quiet
  assign grant_data = arb_en && data_req && !(inst_req && starved);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_inst) begin
      starve_cnt <= '0;
    end else if (grant_data && inst_req && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Purpose: shares one AXI AR/R channel between fetch and load, one transaction in flight.
// Latency: addr_ok same cycle as req; best case data_ok three cycles later.
// Backpressure: holds arvalid/araddr/arid until arready; no new accept until back in IDLE.
module axi_rd_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int         STARVE_LIMIT = 2,
  parameter logic [3:0] INST_ID      = INST_ID_DEF,
  parameter logic [3:0] DATA_ID      = DATA_ID_DEF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  rd_state_e   state_q, state_d;
  logic [1:0]  size_q;
  logic        owner_data_q;
  logic        arb_en;
  logic        grant_inst, grant_data;
  logic        beat_ok, beat_bad;

  // gating with reset keeps addr_ok low while reset is held
  assign arb_en = (state_q == ST_IDLE) && !areset;

  rd_grant_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant_sel (
    .clk        (aclk),
    .rst        (areset),
    .arb_en     (arb_en),
    .inst_req   (inst_req),
    .data_req   (data_req),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  assign arvalid = (state_q == ST_ADDR);
  assign rready  = (state_q == ST_DATA);
  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign arsize  = {1'b0, size_q};

  assign beat_ok  = (state_q == ST_DATA) && rvalid && (rid == arid);
  assign beat_bad = (state_q == ST_DATA) && rvalid && (rid != arid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_inst || grant_data) state_d = ST_ADDR;
      ST_ADDR: if (arready)                  state_d = ST_DATA;
      ST_DATA: if (beat_ok)                  state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      araddr       <= '0;
      arid         <= '0;
      size_q       <= '0;
      owner_data_q <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      rd_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      rd_err       <= beat_bad || (beat_ok && (rresp != RESP_OKAY));
      if (grant_inst) begin
        araddr       <= inst_addr;
        arid         <= INST_ID;
        size_q       <= inst_size;
        owner_data_q <= 1'b0;
      end else if (grant_data) begin
        araddr       <= data_addr;
        arid         <= DATA_ID;
        size_q       <= data_size;
        owner_data_q <= 1'b1;
      end
      if (beat_ok) begin
        if (owner_data_q) begin
          data_rdata   <= rdata;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= rdata;
          inst_data_ok <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter; completions are matched against an expected-beat queue.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0;
  logic [1:0]  inst_size = '0, data_size = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, rready, rd_err;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;

  typedef struct packed {
    logic        inst_ok;
    logic        data_ok;
    logic [31:0] dat;
    logic        err;
  } beat_t;

  beat_t sb[$];
  beat_t obs[$];
  int checks = 0;
  int passed = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  // advance to the next falling edge, logging any completion seen there
  task automatic cycle();
    beat_t b;
    @(negedge aclk);
    if (inst_data_ok || data_data_ok) begin
      b.inst_ok = inst_data_ok;
      b.data_ok = data_data_ok;
      b.dat     = data_data_ok ? data_rdata : inst_rdata;
      b.err     = rd_err;
      obs.push_back(b);
    end
  endtask

  // called in the first ADDR cycle: AR handshake, then one R beat; returns at the data_ok edge
  task automatic serve(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp);
    arready = 1'b1;
    cycle();
    arready = 1'b0;
    rvalid = 1'b1; rid = id; rdata = d; rresp = resp;
    cycle();
    rvalid = 1'b0; rresp = 2'b00;
  endtask

  task automatic test_reset();
    cycle(); cycle();
    #1;
    checks++;
    if ({arvalid, rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, rd_err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000",
               {arvalid, rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, rd_err});
    else passed++;
    checks++;
    if ({araddr, arid, arsize, inst_rdata, data_rdata} !== '0)
      $display("FAIL reset_regs: araddr=%h arid=%h arsize=%h irdata=%h drdata=%h want all 0",
               araddr, arid, arsize, inst_rdata, data_rdata);
    else passed++;
    checks++;
    if (arlen !== 8'd0 || arburst !== 2'b01)
      $display("FAIL reset_const: arlen=%h arburst=%b want 00/01", arlen, arburst);
    else passed++;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_single_fetch();
    beat_t o, e;
    inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = 2'd2;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10)
      $display("FAIL fetch_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok});
    else passed++;
    sb.push_back(beat_t'{1'b1, 1'b0, 32'h3C1DBFC0, 1'b0});
    cycle();
    inst_req = 1'b0;
    checks++;
    if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'hBFC00000, 4'd0, 3'b010})
      $display("FAIL fetch_ar: got v=%b a=%h id=%h sz=%b want 1 bfc00000 0 010",
               arvalid, araddr, arid, arsize);
    else passed++;
    arready = 1'b1;
    cycle();
    arready = 1'b0;
    checks++;
    if ({arvalid, rready} !== 2'b01)
      $display("FAIL fetch_data_state: got arvalid/rready=%b want 01", {arvalid, rready});
    else passed++;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C1DBFC0; rresp = 2'b00;
    cycle();
    rvalid = 1'b0;
    checks++;
    if (obs.size() == 0 || sb.size() == 0)
      $display("FAIL fetch_beat: completions seen=%0d expected=%0d", obs.size(), sb.size());
    else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o !== e) $display("FAIL fetch_beat: got %h want %h", o, e);
      else passed++;
    end
    cycle();
    checks++;
    if (inst_data_ok !== 1'b0 || inst_rdata !== 32'h3C1DBFC0)
      $display("FAIL fetch_pulse_hold: data_ok=%b rdata=%h want 0 3c1dbfc0", inst_data_ok, inst_rdata);
    else passed++;
  endtask

  task automatic test_priority();
    beat_t o, e;
    logic exp_inst [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] d;
    inst_req = 1'b1; inst_addr = 32'h00001000; inst_size = 2'd2;
    data_req = 1'b1; data_addr = 32'h00002000; data_size = 2'd2;
    for (int k = 0; k < 6; k++) begin
      #1;
      d = 32'hA0000000 + 32'(k);
      checks++;
      if ({inst_addr_ok, data_addr_ok} !== (exp_inst[k] ? 2'b10 : 2'b01))
        $display("FAIL prio_grant%0d: got %b want %b", k, {inst_addr_ok, data_addr_ok},
                 exp_inst[k] ? 2'b10 : 2'b01);
      else passed++;
      sb.push_back(beat_t'{exp_inst[k], !exp_inst[k], d, 1'b0});
      cycle();
      checks++;
      if (arid !== (exp_inst[k] ? 4'd0 : 4'd1) || araddr !== (exp_inst[k] ? 32'h1000 : 32'h2000))
        $display("FAIL prio_ar%0d: got id=%h addr=%h want owner inst=%b", k, arid, araddr, exp_inst[k]);
      else passed++;
      serve(exp_inst[k] ? 4'd0 : 4'd1, d, 2'b00);
      if (k == 5) begin
        inst_req = 1'b0; data_req = 1'b0;
      end
      checks++;
      if (obs.size() == 0 || sb.size() == 0)
        $display("FAIL prio_beat%0d: completions seen=%0d expected=%0d", k, obs.size(), sb.size());
      else begin
        o = obs.pop_front(); e = sb.pop_front();
        if (o !== e) $display("FAIL prio_beat%0d: got %h want %h", k, o, e);
        else passed++;
      end
    end
  endtask

  task automatic test_ar_backpressure();
    beat_t o, e;
    data_req = 1'b1; data_addr = 32'h80000010; data_size = 2'd1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01)
      $display("FAIL bp_addr_ok: got %b want 01", {inst_addr_ok, data_addr_ok});
    else passed++;
    sb.push_back(beat_t'{1'b0, 1'b1, 32'h600DCAFE, 1'b0});
    cycle();
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h00005000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({arvalid, araddr, arid, arsize, inst_addr_ok, data_addr_ok} !==
          {1'b1, 32'h80000010, 4'd1, 3'b001, 1'b0, 1'b0})
        $display("FAIL bp_hold%0d: got v=%b a=%h id=%h sz=%b ok=%b want 1 80000010 1 001 00", k,
                 arvalid, araddr, arid, arsize, {inst_addr_ok, data_addr_ok});
      else passed++;
      cycle();
    end
    inst_req = 1'b0;
    serve(4'd1, 32'h600DCAFE, 2'b00);
    checks++;
    if (obs.size() == 0 || sb.size() == 0)
      $display("FAIL bp_beat: completions seen=%0d expected=%0d", obs.size(), sb.size());
    else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o !== e) $display("FAIL bp_beat: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_error_resp();
    beat_t o, e;
    data_req = 1'b1; data_addr = 32'h00000100; data_size = 2'd2;
    #1;
    sb.push_back(beat_t'{1'b0, 1'b1, 32'hDEADBEEF, 1'b1});
    cycle();
    data_req = 1'b0;
    serve(4'd1, 32'hDEADBEEF, 2'b10);
    checks++;
    if ({data_data_ok, rd_err, data_rdata} !== {1'b1, 1'b1, 32'hDEADBEEF})
      $display("FAIL err_same_cycle: got ok=%b err=%b rdata=%h want 1 1 deadbeef",
               data_data_ok, rd_err, data_rdata);
    else passed++;
    checks++;
    if (obs.size() == 0 || sb.size() == 0)
      $display("FAIL err_beat: completions seen=%0d expected=%0d", obs.size(), sb.size());
    else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o !== e) $display("FAIL err_beat: got %h want %h", o, e);
      else passed++;
    end
    cycle();
    checks++;
    if ({data_data_ok, rd_err} !== 2'b00)
      $display("FAIL err_pulse: got ok/err=%b want 00", {data_data_ok, rd_err});
    else passed++;
  endtask

  task automatic test_rid_mismatch();
    beat_t o, e;
    data_req = 1'b1; data_addr = 32'h00000200; data_size = 2'd2;
    #1;
    sb.push_back(beat_t'{1'b0, 1'b1, 32'h22222222, 1'b0});
    cycle();
    data_req = 1'b0;
    arready = 1'b1;
    cycle();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h11111111; rresp = 2'b00;
    cycle();
    rvalid = 1'b0;
    checks++;
    if ({rd_err, inst_data_ok, data_data_ok, rready} !== 4'b1001 || obs.size() != 0)
      $display("FAIL rid_drop: got err/iok/dok/rready=%b seen=%0d want 1001 0",
               {rd_err, inst_data_ok, data_data_ok, rready}, obs.size());
    else passed++;
    cycle();
    checks++;
    if (rd_err !== 1'b0)
      $display("FAIL rid_err_pulse: got %b want 0", rd_err);
    else passed++;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h22222222;
    cycle();
    rvalid = 1'b0;
    checks++;
    if (obs.size() == 0 || sb.size() == 0)
      $display("FAIL rid_beat: completions seen=%0d expected=%0d", obs.size(), sb.size());
    else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o !== e) $display("FAIL rid_beat: got %h want %h", o, e);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    beat_t o, e;
    data_req = 1'b1; data_addr = 32'h00003000; data_size = 2'd2;
    #1;
    cycle();
    data_req = 1'b0;
    arready = 1'b1;
    cycle();
    arready = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, inst_data_ok, data_data_ok, rd_err, araddr, arid, inst_rdata, data_rdata} !== '0)
      $display("FAIL rst_async: v=%b r=%b a=%h id=%h irdata=%h drdata=%h want all 0",
               arvalid, rready, araddr, arid, inst_rdata, data_rdata);
    else passed++;
    cycle(); cycle();
    areset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h00004000; inst_size = 2'd2;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10 || obs.size() != 0)
      $display("FAIL rst_reaccept: got ok=%b seen=%0d want 10 0", {inst_addr_ok, data_addr_ok}, obs.size());
    else passed++;
    sb.push_back(beat_t'{1'b1, 1'b0, 32'h00000077, 1'b0});
    cycle();
    inst_req = 1'b0;
    serve(4'd0, 32'h00000077, 2'b00);
    checks++;
    if (obs.size() == 0 || sb.size() == 0)
      $display("FAIL rst_beat: completions seen=%0d expected=%0d", obs.size(), sb.size());
    else begin
      o = obs.pop_front(); e = sb.pop_front();
      if (o !== e) $display("FAIL rst_beat: got %h want %h", o, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_ar_backpressure();
    test_error_resp();
    test_rid_mismatch();
    test_reset_mid();
    cycle();
    checks++;
    if (obs.size() != 0 || sb.size() != 0)
      $display("FAIL leftover: seen=%0d expected=%0d want 0 0", obs.size(), sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read channel (AR/R) of the MIPS core between two requesters: instruction fetch (inst_*) and data load (data_*).
- Each requester uses a SRAM-like handshake: req/addr/size in, addr_ok/data_ok/rdata out.
- Sits inside the CPU-to-AXI bridge, between the pipeline fetch/memory stages and the AXI master ports of the top level.
- Fixed data-over-instruction priority, with a starvation guard for fetch. One outstanding transaction at a time.

Parameters:
- STARVE_LIMIT, 2: consecutive lost arbitrations after which inst wins regardless of data_req. Legal range 1..15.
- INST_ID, 4'd0: arid/rid tag used for instruction reads.
- DATA_ID, 4'd1: arid/rid tag used for data reads.

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
inst_req  in  1  fetch read request
inst_addr  in  32  fetch byte address
inst_size  in  2  log2 bytes (0=1B, 1=2B, 2=4B)
inst_addr_ok  out  1  fetch request accepted (pulse)
inst_data_ok  out  1  fetch data valid (pulse)
inst_rdata  out  32  fetch read data
data_req  in  1  load read request
data_addr  in  32  load byte address
data_size  in  2  log2 bytes
data_addr_ok  out  1  load request accepted (pulse)
data_data_ok  out  1  load data valid (pulse)
data_rdata  out  32  load read data
arid  out  4  AXI read id
araddr  out  32  AXI read address
arlen  out  8  constant 0 (single beat)
arsize  out  3  {1'b0, latched size}
arburst  out  2  constant 2'b01
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid  in  4  AXI R id
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rd_err  out  1  one-cycle pulse on rresp!=0 or unexpected rid

Behaviour:
- Clock is aclk. Reset is areset, asynchronous and active-high.
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- Reset values: arvalid, rready, *_addr_ok, *_data_ok and rd_err are 0. araddr, arid, *_rdata are 0. Starvation counter is 0. Owner register is inst.
- IDLE, grant rule:
  - inst wins when data_req=0, or when starve_cnt==STARVE_LIMIT.
  - Otherwise data wins.
- IDLE, combinational accept: the winner's addr_ok=1 in the same cycle. Latch addr, size, owner and id; go to ADDR.
- IDLE with no req: stay in IDLE; no addr_ok.
- Starvation counter update:
  - Increments (saturating at STARVE_LIMIT) when inst_req and data_req are both 1 and data wins.
  - Clears to 0 whenever inst is granted.
  - Otherwise holds.
- ADDR:
  - arvalid=1. araddr, arid and arsize stay stable until arready.
  - On arvalid&&arready, go to DATA; arvalid falls the next cycle.
  - No addr_ok is issued while in ADDR or DATA.
- DATA:
  - rready=1.
  - On rvalid with rid==latched id: register rdata into the owner's *_rdata; pulse the owner's data_ok for exactly one cycle (the cycle after the handshake); return to IDLE.
  - If rresp!=0 on that beat: data_ok and rdata are still delivered, and rd_err pulses alongside data_ok.
  - On rvalid with rid!=latched id: the beat is consumed and dropped; rd_err pulses the next cycle; stay in DATA.
- Best-case latency: req/addr_ok at cycle 0; arvalid at 1. With arready at 1 and rvalid at 2, data_ok is at 3.
- The next request can be accepted in the cycle data_ok is high, since the FSM is back in IDLE.
- *_rdata holds its value between transactions.
- Reset mid-transaction: the FSM returns to IDLE at once and the outstanding AXI read is abandoned. No data_ok is issued for it. The top level asserts AXI reset together with areset.
- Request signals are sampled only in IDLE. Requesters hold req/addr until addr_ok.

Decomposition:
- Shared package (cpu_axi_pkg) holds:
  - FSM state encoding (IDLE=0, ADDR=1, DATA=2).
  - AXI constants: BURST_INCR=2'b01, LEN_SINGLE=8'd0, RESP_OKAY=2'b00.
  - Default id tags.
- One sub-module is natural: rd_grant_sel. It is the combinational priority/starvation selector plus the saturating counter register.

Test Plan:
1. Single fetch: inst_req=1, addr=0xBFC00000, size=2. Expect inst_addr_ok at c0; araddr=0xBFC00000, arid=0, arsize=3'b010 at c1. Then with arready=1 at c1 and rvalid=1, rid=0, rdata=0x3C1DBFC0 at c2, inst_data_ok=1 with inst_rdata=0x3C1DBFC0 at c3.
2. Simultaneous requests, both held continuously: expect grants in the order data, data, inst, data, data, inst. starve_cnt reaches 2 before each inst grant and clears after it.
3. AR backpressure: arready low for 5 cycles. arvalid stays 1 with araddr/arid stable for the whole window, and no addr_ok is issued. Transfer completes after arready=1.
4. Error response: data read returns rresp=2'b10, rdata=0xDEADBEEF. data_data_ok=1, data_rdata=0xDEADBEEF and rd_err=1 in the same cycle.
5. Mismatched rid: in DATA with latched id 1, send rid=0. Beat is dropped, rd_err pulses, no data_ok. A following rid=1 beat completes normally.
6. Reset mid-DATA: assert areset while in DATA. All outputs drop to 0 asynchronously. After release, the FSM is in IDLE, no data_ok fires, and a new inst_req is accepted at once.
